mean_pack: RTL and testbench
============================

MEAN_PACK -- requirements
Module: mean_pack

Interface
REQ-001 Parameter LINE_NUM, default 12: byte lanes per input beat and per output word.
REQ-002 Parameter FIFO_DEPTH, default 4: output FIFO entries, power of two, at least 2.
REQ-003 Port i_clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 Port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port i_data_valid, input, 1: input beat present, with no back-pressure to upstream.
REQ-006 Port i_rank, input, 2: downsample rank of the beat; 0/1/2/3 means 12/6/4/3 valid low bytes.
REQ-007 Port i_sync_h, input, 1: line-activity strobe; its falling edge marks end of line.
REQ-008 Port i_data, input, LINE_NUM*8: beat bytes; lane k is bits [8k+7:8k].
REQ-009 Port i_ready, input, 1: downstream accepts a word when o_valid and i_ready are both high.
REQ-010 Port o_valid, output, 1: output FIFO non-empty.
REQ-011 Port o_data, output, LINE_NUM*8: packed word at the FIFO head.
REQ-012 Port o_last, output, 1: the head word is the final word of a line.
REQ-013 Port o_rank, output, 2: rank of the head word.
REQ-014 Port o_ovf, output, 1: sticky flag, set when a word was dropped because the FIFO was full.

Function
REQ-015 Valid bytes per beat SHALL be n = 12, 6, 4 or 3 for rank 0, 1, 2 or 3, always the low lanes; the upper lanes SHALL be ignored.
REQ-016 The packer SHALL hold a LINE_NUM-byte accumulator and a fill count (0..12) and write beat lane k to accumulator byte fill+k.
REQ-017 When fill+n reaches 12, the accumulator SHALL be pushed to the FIFO one cycle after the completing beat, and fill SHALL return to 0.
REQ-018 The FSM SHALL have three states:
  - IDLE: fill = 0.
  - FILL: partial word held.
  - FLUSH: one cycle, pushes a partial word.
REQ-019 FSM transitions:
  - IDLE to FILL on a beat that leaves 0 < fill < 12.
  - FILL to FLUSH on a falling edge of i_sync_h, or on a beat whose i_rank differs from the latched word rank.
  - FLUSH to IDLE; or FLUSH to FILL when a rank-change beat is pending.
REQ-020 On a flush, unused accumulator bytes SHALL be zero, and the pushed word SHALL carry the latched rank.
REQ-021 On a rank change, the beat that carries the new rank SHALL be held for one cycle and written after the flush, so no data is lost.
REQ-022 The word pushed at or completed by an i_sync_h falling edge SHALL have last = 1.
  - A completed-word push takes priority over a flush in the same cycle; no empty word is ever produced.
  - If fill = 0 at the falling edge, last SHALL be set on the most recent pushed word only if that word is still in the FIFO; otherwise no last is emitted.
REQ-023 Word rank SHALL be latched from the first beat of each word.
REQ-024 The FIFO SHALL be first-word-fall-through; a simultaneous push and pop SHALL both succeed when the FIFO is full.
REQ-025 A push to a full FIFO without a pop SHALL drop the word and set o_ovf, which stays set until reset.
REQ-026 Latency: a completing beat in cycle N SHALL give o_valid = 1 in cycle N+1 when the FIFO is empty.

Reset
REQ-027 Asserting i_rst_n low SHALL immediately clear the following, with no clock required:
  - the FSM to IDLE, fill and the accumulator to 0;
  - the FIFO to empty;
  - outputs: o_valid = 0, o_data = 0, o_last = 0, o_rank = 0, o_ovf = 0.
REQ-028 Reset mid-line SHALL discard the partial word and buffered words; the first beat after release starts a new word.

Configuration
REQ-029 When macro MEAN_PACK_OVF_CNT_EN is defined, an extra output o_ovf_cnt (16 bits) SHALL count dropped words, saturating at 0xFFFF and reset to 0.
REQ-030 When MEAN_PACK_OVF_CNT_EN is undefined, the o_ovf_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Rank 0: three beats 0x0B..00, 0x1B..10, 0x2B..20, i_ready = 1 -> three words, identical to the beats, each one cycle later.
REQ-032 Rank 3: four beats with low bytes {03,02,01}, {06,05,04}, {09,08,07}, {0C,0B,0A} -> one word 0x0C0B..01 with rank 3, one cycle after the fourth beat.
REQ-033 Rank 1: three beats then an i_sync_h fall -> word 1 full; word 2 has 6 valid bytes, upper 6 bytes zero, last = 1.
REQ-034 Rank 2: two beats, then a rank-0 beat -> a flushed rank-2 word (8 bytes valid, last = 0), then the rank-0 word.
REQ-035 i_ready = 0 with FIFO_DEPTH + 1 rank-0 beats -> four words held, o_ovf = 1; with MEAN_PACK_OVF_CNT_EN defined, o_ovf_cnt = 1.
REQ-036 Drive i_rst_n low between clock edges while two rank-3 beats are accumulated -> o_valid = 0 immediately; the next four beats give one clean word.

Source files
------------

// File: rtl/mean_pack.sv
// mean_pack: packs downsampled byte beats (12/6/4/3 valid low lanes per beat,
// chosen by rank) into LINE_NUM-byte words, flushing partial words at end of
// line or on a rank change, and queues them in a first-word-fall-through FIFO.
// Optional build macro MEAN_PACK_OVF_CNT_EN adds o_ovf_cnt, a saturating count
// of words dropped because the FIFO was full.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | accumulator empty (fill = 0)
// S_FILL  | partial word held in the accumulator
// S_FLUSH | one cycle: push the partial word, then load any held beat
//
// A beat that changes rank is parked in a one-beat holding register while the
// old word is flushed. A held rank-0 beat is a complete word by itself, so it
// stays parked through the flush and is pushed from S_IDLE on the next cycle.
module mean_pack #(
    parameter int LINE_NUM   = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_data_valid,
    input  logic [1:0]            i_rank,
    input  logic                  i_sync_h,
    input  logic [LINE_NUM*8-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [LINE_NUM*8-1:0] o_data,
    output logic                  o_last,
    output logic [1:0]            o_rank,
    output logic                  o_ovf
`ifdef MEAN_PACK_OVF_CNT_EN
    ,
    output logic [15:0]           o_ovf_cnt
`endif
);

    localparam int W  = LINE_NUM * 8;
    localparam int FW = $clog2(LINE_NUM + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH} state_t;

    function automatic logic [FW-1:0] lanes(input logic [1:0] r);
        case (r)
            2'd0:    lanes = FW'(LINE_NUM);
            2'd1:    lanes = FW'(LINE_NUM / 2);
            2'd2:    lanes = FW'(LINE_NUM / 3);
            default: lanes = FW'(LINE_NUM / 4);
        endcase
    endfunction

    // Copy the low n lanes of src into base starting at byte position at.
    function automatic logic [W-1:0] merge_lanes(input logic [W-1:0]  base,
                                                 input logic [FW-1:0] at,
                                                 input logic [W-1:0]  src,
                                                 input logic [FW-1:0] n);
        logic [W-1:0] res;
        res = base;
        for (int k = 0; k < LINE_NUM; k++) begin
            if (k < int'(n) && int'(at) + k < LINE_NUM)
                res[(int'(at) + k)*8 +: 8] = src[k*8 +: 8];
        end
        return res;
    endfunction

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [FW-1:0]  fill_q, fill_d;
    logic [1:0]     wrank_q, wrank_d;
    logic           sync_q;
    logic           pend_v_q, pend_v_d;
    logic [1:0]     pend_rank_q, pend_rank_d;
    logic [W-1:0]   pend_data_q, pend_data_d;
    logic           flush_last_q, flush_last_d;

    logic [W-1:0]   mem_data [FIFO_DEPTH];
    logic [1:0]     mem_rank [FIFO_DEPTH];
    logic           mem_last [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  cnt_q;
    logic           ovf_q;

    logic           fall;
    logic           eff_v;
    logic [1:0]     eff_rank;
    logic [W-1:0]   eff_data;
    logic [FW-1:0]  n_eff;
    logic [W-1:0]   merged;
    logic           completes;
    logic           rank_diff;
    logic           pend_loads;

    logic           push;
    logic [W-1:0]   push_data;
    logic [1:0]     push_rank;
    logic           push_last;
    logic           mark_last;
    logic           pop, full, accept, drop;

    // Effective beat (held beat first) and its merge into the accumulator.
    always_comb begin
        fall       = sync_q & ~i_sync_h;
        eff_v      = pend_v_q | i_data_valid;
        eff_rank   = pend_v_q ? pend_rank_q : i_rank;
        eff_data   = pend_v_q ? pend_data_q : i_data;
        n_eff      = lanes(eff_rank);
        merged     = merge_lanes(acc_q, fill_q, eff_data, n_eff);
        completes  = (int'(fill_q) + int'(n_eff)) >= LINE_NUM;
        rank_diff  = (fill_q != '0) && (eff_rank != wrank_q);
        pend_loads = pend_v_q && (lanes(pend_rank_q) < FW'(LINE_NUM));
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FILL: begin
                if (eff_v) begin
                    if (rank_diff)      state_d = S_FLUSH;
                    else if (completes) state_d = S_IDLE;
                    else if (fall)      state_d = S_FLUSH;
                    else                state_d = S_FILL;
                end else if (fall && fill_q != '0) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: state_d = pend_loads ? S_FILL : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: FIFO push request and next accumulator / holding contents.
    always_comb begin
        push         = 1'b0;
        push_data    = acc_q;
        push_rank    = wrank_q;
        push_last    = 1'b0;
        mark_last    = 1'b0;
        acc_d        = acc_q;
        fill_d       = fill_q;
        wrank_d      = wrank_q;
        pend_v_d     = pend_v_q;
        pend_rank_d  = pend_rank_q;
        pend_data_d  = pend_data_q;
        flush_last_d = flush_last_q;
        case (state_q)
            S_FLUSH: begin
                push         = 1'b1;
                push_last    = flush_last_q | fall;
                flush_last_d = 1'b0;
                acc_d        = '0;
                fill_d       = '0;
                if (pend_loads) begin
                    acc_d   = merge_lanes('0, '0, pend_data_q, lanes(pend_rank_q));
                    fill_d  = lanes(pend_rank_q);
                    wrank_d = pend_rank_q;
                end
                if (!pend_v_q || pend_loads) begin
                    pend_v_d    = i_data_valid;
                    pend_rank_d = i_rank;
                    pend_data_d = i_data;
                end
            end
            default: begin
                if (eff_v) begin
                    if (pend_v_q) begin
                        pend_v_d    = i_data_valid;
                        pend_rank_d = i_rank;
                        pend_data_d = i_data;
                    end
                    if (rank_diff) begin
                        pend_v_d     = 1'b1;
                        pend_rank_d  = eff_rank;
                        pend_data_d  = eff_data;
                        flush_last_d = fall;
                    end else if (completes) begin
                        push      = 1'b1;
                        push_data = merged;
                        push_rank = (fill_q == '0) ? eff_rank : wrank_q;
                        push_last = fall;
                        acc_d     = '0;
                        fill_d    = '0;
                    end else begin
                        acc_d        = merged;
                        fill_d       = fill_q + n_eff;
                        wrank_d      = (fill_q == '0) ? eff_rank : wrank_q;
                        flush_last_d = fall;
                    end
                end else if (fall) begin
                    if (fill_q != '0) flush_last_d = 1'b1;
                    else              mark_last    = 1'b1;
                end
            end
        endcase
    end

    // Accumulator, holding register and line-strobe history.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q        <= '0;
            fill_q       <= '0;
            wrank_q      <= '0;
            sync_q       <= 1'b0;
            pend_v_q     <= 1'b0;
            pend_rank_q  <= '0;
            pend_data_q  <= '0;
            flush_last_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            wrank_q      <= wrank_d;
            sync_q       <= i_sync_h;
            pend_v_q     <= pend_v_d;
            pend_rank_q  <= pend_rank_d;
            pend_data_q  <= pend_data_d;
            flush_last_q <= flush_last_d;
        end
    end

    assign pop    = o_valid & i_ready;
    assign full   = (cnt_q == CW'(FIFO_DEPTH));
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(accept) - CW'(pop);
            if (drop) ovf_q <= 1'b1;
        end
    end

    // FIFO storage; an end of line with nothing accumulated tags the newest entry.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem_data[wr_ptr_q] <= push_data;
            mem_rank[wr_ptr_q] <= push_rank;
            mem_last[wr_ptr_q] <= push_last;
        end
        if (mark_last && cnt_q != '0)
            mem_last[wr_ptr_q - PW'(1)] <= 1'b1;
    end

    assign o_valid = (cnt_q != '0);
    assign o_data  = o_valid ? mem_data[rd_ptr_q] : '0;
    assign o_rank  = o_valid ? mem_rank[rd_ptr_q] : '0;
    assign o_last  = o_valid ? mem_last[rd_ptr_q] : 1'b0;
    assign o_ovf   = ovf_q;

`ifdef MEAN_PACK_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    // Saturating count of dropped words.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                     ovf_cnt_q <= '0;
        else if (drop && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end

    assign o_ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_mean_pack.sv
// Scoreboard bench for mean_pack: a byte-queue reference model pushes expected
// words as beats are issued; a negedge monitor pops and compares on each transfer.
module tb_mean_pack;
    localparam int LN = 12;
    localparam int FD = 4;
    localparam int W  = LN * 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         dv    = 1'b0;
    logic         sync  = 1'b1;
    logic         rdy   = 1'b0;
    logic [1:0]   rank  = 2'd0;
    logic [W-1:0] din   = '0;
    logic         o_valid, o_last, o_ovf;
    logic [W-1:0] o_data;
    logic [1:0]   o_rank;
`ifdef MEAN_PACK_OVF_CNT_EN
    logic [15:0]  o_ovf_cnt;
`endif

    always #5 clk = ~clk;

    mean_pack #(.LINE_NUM(LN), .FIFO_DEPTH(FD)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data_valid (dv),
        .i_rank       (rank),
        .i_sync_h     (sync),
        .i_data       (din),
        .i_ready      (rdy),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_last       (o_last),
        .o_rank       (o_rank),
        .o_ovf        (o_ovf)
`ifdef MEAN_PACK_OVF_CNT_EN
        ,
        .o_ovf_cnt    (o_ovf_cnt)
`endif
    );

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   rank;
        logic         last;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] cur[$];
    logic [1:0] cur_rank = 2'd0;
    int         drops    = 0;
    int         n_checks = 0;
    int         n_pass   = 0;
    word_t      mon_w;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int nbytes(input logic [1:0] r);
        return LN / (int'(r) + 1);
    endfunction

    // Close the current word: zero-pad, then queue it or count it as dropped.
    task automatic emit(input bit last);
        word_t w;
        w.data = '0;
        for (int i = 0; i < cur.size(); i++) w.data[i*8 +: 8] = cur[i];
        w.rank = cur_rank;
        w.last = last;
        cur.delete();
        if (exp_q.size() >= FD) drops++;
        else exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] r, input logic [W-1:0] d, input bit fall);
        if (cur.size() > 0 && r != cur_rank) emit(1'b0);
        if (cur.size() == 0) cur_rank = r;
        for (int k = 0; k < nbytes(r); k++) cur.push_back(d[k*8 +: 8]);
        if (cur.size() == LN) emit(fall);
        else if (fall) emit(1'b1);
        dv = 1'b1; rank = r; din = d; sync = ~fall;
        tick();
        dv = 1'b0; sync = 1'b1; din = {$urandom, $urandom, $urandom};
    endtask

    task automatic fall_idle();
        if (cur.size() > 0) emit(1'b1);
        else if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
        sync = 1'b0;
        tick();
        sync = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        int budget;
        rdy = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 200) begin
            tick();
            budget++;
        end
        check("drain_empty", exp_q.size(), 0);
        idle(3);
    endtask

    function automatic logic [W-1:0] seq_beat(input int base, input int n);
        logic [W-1:0] d;
        d = {$urandom, $urandom, $urandom};
        for (int k = 0; k < n; k++) d[k*8 +: 8] = 8'(base + k);
        return d;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_valid === 1'b1 && rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got %0h expected none", o_data);
            end else begin
                mon_w = exp_q.pop_front();
                check("word_data", o_data, mon_w.data);
                check("word_rank", o_rank, mon_w.rank);
                check("word_last", o_last, mon_w.last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   r;
        logic [W-1:0] d;
        bit           chg;
        int           act;

        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_data",  o_data, 0);
        check("rst_last",  o_last, 0);
        check("rst_rank",  o_rank, 0);
        check("rst_ovf",   o_ovf, 0);
        idle(2);
        #3 rst_n = 1'b1;
        tick();

        // Rank 0: each beat is a word, visible the next cycle.
        rdy = 1'b1;
        beat(2'd0, seq_beat(8'h00, 12), 1'b0);
        check("latency_valid", o_valid, 1);
        beat(2'd0, seq_beat(8'h10, 12), 1'b0);
        beat(2'd0, seq_beat(8'h20, 12), 1'b0);
        drain();

        // Rank 3: four 3-byte beats make one word.
        for (int i = 0; i < 4; i++) beat(2'd3, seq_beat(3*i + 1, 3), 1'b0);
        check("r3_word", o_data, 96'h0C0B0A090807060504030201);
        check("r3_rank", o_rank, 3);
        drain();

        // Rank 1: end of line flushes a half word with last.
        for (int i = 0; i < 3; i++) beat(2'd1, seq_beat(8'h40 + 6*i, 6), 1'b0);
        fall_idle();
        idle(2);
        drain();

        // Rank 2 then a rank-0 beat: flushed 8-byte word, then the rank-0 word.
        beat(2'd2, seq_beat(8'h60, 4), 1'b0);
        beat(2'd2, seq_beat(8'h64, 4), 1'b0);
        beat(2'd0, seq_beat(8'h80, 12), 1'b0);
        idle(3);
        drain();

        // Completing beat on the falling edge carries last; fall with empty
        // accumulator tags the word still waiting in the FIFO.
        for (int i = 0; i < 3; i++) beat(2'd3, seq_beat(8'hA0 + 3*i, 3), 1'b0);
        beat(2'd3, seq_beat(8'hA9, 3), 1'b1);
        idle(2);
        drain();
        rdy = 1'b0;
        beat(2'd0, seq_beat(8'hC0, 12), 1'b0);
        idle(2);
        fall_idle();
        idle(2);
        drain();

        // Random traffic with random back-pressure, kept below FIFO capacity.
        for (int it = 0; it < 400; it++) begin
            rdy = ($urandom_range(0, 3) != 0);
            act = $urandom_range(0, 9);
            if (act < 6 && exp_q.size() <= FD - 2) begin
                if (cur.size() > 0 && $urandom_range(0, 3) != 0) r = cur_rank;
                else r = 2'($urandom_range(0, 3));
                chg = (cur.size() > 0) && (r != cur_rank);
                d = {$urandom, $urandom, $urandom};
                beat(r, d, 1'b0);
                if (chg) idle(2);
            end else if (act == 6 && cur.size() > 0) begin
                fall_idle();
                idle(2);
            end else begin
                idle(1);
            end
        end
        if (cur.size() > 0) begin
            fall_idle();
            idle(2);
        end
        drain();
        check("ovf_random", o_ovf, 0);

        // Overflow: FIFO_DEPTH + 1 words with no pops.
        rdy = 1'b0;
        for (int i = 0; i <= FD; i++) beat(2'd0, {$urandom, $urandom, $urandom}, 1'b0);
        idle(2);
        check("ovf_set", o_ovf, drops > 0);
        check("ovf_held", o_valid, 1);
`ifdef MEAN_PACK_OVF_CNT_EN
        check("ovf_cnt", o_ovf_cnt, drops);
`endif
        drain();
        check("ovf_sticky", o_ovf, 1);

        // Asynchronous reset mid-line discards buffered and partial words.
        rdy = 1'b0;
        beat(2'd0, {$urandom, $urandom, $urandom}, 1'b0);
        beat(2'd3, seq_beat(8'h50, 3), 1'b0);
        beat(2'd3, seq_beat(8'h53, 3), 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", o_valid, 0);
        check("arst_data",  o_data, 0);
        check("arst_ovf",   o_ovf, 0);
        exp_q.delete();
        cur.delete();
        drops = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) beat(2'd3, seq_beat(8'hE0 + 3*i, 3), 1'b0);
        check("post_rst_word", o_data, 96'hEBEAE9E8E7E6E5E4E3E2E1E0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
